four_to_two_encoder: RTL and testbench
======================================

# four_to_two_encoder

Sequential 4-to-2 encoder. It is the return path for the 2-to-4 decoder. Rising edges on the four one-hot-style request lines `d0`–`d3` are captured into a pending set. Each pending request is then presented, one at a time, as a 2-bit code `{a,b}` with a valid/ready handshake. Events that cannot be queued are counted in a saturating overflow counter, so bursty or multi-hot inputs never produce an ambiguous code.

## Interface
- `OVF_W`, default 8: width of the saturating dropped-event counter.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `d0`, `d1`, `d2`, `d3`  in  1 each: request lines, synchronous to `clk`; a 0→1 transition is one event.
- `a`  out  1: code MSB (index bit 1).
- `b`  out  1: code LSB (index bit 0).
- `valid`  out  1: `{a,b}` holds a valid code.
- `ready`  in  1: consumer accepts the code when `valid && ready` at a clock edge.
- `ovf`  out  1: one-cycle pulse when an event is dropped.
- `ovf_cnt`  out  `OVF_W`: saturating count of dropped events.
- `idle`  out  1: high when there is no pending request and `valid = 0`.

## Operation
- Edge detect:
  - `prev[3:0]` registers `{d3,d2,d1,d0}` every cycle.
  - `rise = d & ~prev`.
  - `prev` resets to 0, so a line already high when reset releases counts as an event on the first cycle.
- Pending set `pend[3:0]`:
  - Bit i is set on `rise[i]`.
  - Bit i is cleared when index i is loaded into the output register.
  - If set and clear hit the same bit in the same cycle, set wins and the bit stays pending.
- Drop rule:
  - A drop is `rise[i]` while `pend[i] = 1`, unless `pend[i]` is being cleared that same cycle.
  - Each drop adds 1 to `ovf_cnt`, which saturates at 2^OVF_W−1.
  - Several drops in one cycle add their count, saturated.
  - `ovf` pulses high for any drop in that cycle.
- Selection:
  - Fixed priority by default: d3 > d2 > d1 > d0.
  - Code = index of the selected line: d0→00, d1→01, d2→10, d3→11.
- FSM, two states:
  - **IDLE** (`valid = 0`):
    - If `pend != 0`, load the selected code, clear its pend bit, and go to SHOW.
    - Otherwise stay in IDLE.
  - **SHOW** (`valid = 1`):
    - `{a,b}` stays stable while `ready = 0`.
    - On `valid && ready` with other pend bits set (excluding bits set this cycle by `rise`): load the next selection in the same cycle and stay in SHOW. This gives back-to-back codes at one per cycle.
    - On `valid && ready` with no other pend bits set: go to IDLE and drive `valid = 0`.
- Multi-hot inputs: simultaneous edges all become pending and are served in priority order. No edge is lost.

## Timing
- Reset values:
  - State IDLE; `a = b = 0`; `valid = 0`; `ovf = 0`; `ovf_cnt = 0`; `pend = 0`; `prev = 0`; `idle = 1`.
  - The round-robin pointer resets to 3.
- Latency: if `dN` is low at edge k−1 and high at edge k, then `pend[N] = 1` after edge k, and `valid = 1` with `{a,b} = N` after edge k+1. Total latency is 2 cycles.
- Throughput: 1 code per cycle while `ready = 1` and requests are pending.
- `ovf` is registered. It is asserted the cycle after the edge that caused the drop.
- `idle` is combinational from the state and `pend` registers only.
- Reset asserted mid-transfer:
  - All state clears immediately and asynchronously.
  - Any presented code is discarded without a handshake.

## Configuration
- `ENC_RR_EN` defined:
  - Selection is round-robin.
  - A 2-bit pointer `last` is updated on each load.
  - The search starts at index `last+1` and wraps from 3 to 0.
  - Because `last` resets to 3, the first search starts at d0.
- `ENC_RR_EN` undefined:
  - Fixed priority d3 > d2 > d1 > d0.
  - No pointer register exists.

## Structure
- Package `encoder_pkg` holds:
  - The state enum (`ST_IDLE`, `ST_SHOW`).
  - `CODE_W = 2` and `NREQ = 4`.
  - The code constants `CODE_D0` … `CODE_D3`.
- Sub-module `rise_detect`, parameterised width (4 here): contains the `prev` register and the `rise` output.
- The selection function (fixed or round-robin) stays local to the top module.

## Test plan
- Reset release with all lines low, then pulse `d1` for one cycle while `ready = 1` → 2 cycles later `valid = 1` and `{a,b} = 01` for exactly 1 cycle; `idle` returns to 1.
- `ready = 0`, rising edges on `d0` and `d3` in the same cycle, then `ready = 1` → codes 11 then 00 on consecutive cycles (fixed priority). With `ENC_RR_EN`, the order is 00 then 11.
- Hold `ready = 0` for 10 cycles while `valid = 1` → `{a,b}` stable for all 10 cycles, with no change to `valid`.
- Toggle `d2` 0→1→0→1 while `pend[2]` is still set and `ready = 0` → `ovf` pulses once, `ovf_cnt = 1`, and code 10 is presented once.
- With `OVF_W = 2`, cause 5 drops → `ovf_cnt` saturates at 3.
- Assert `rst_n = 0` while `valid = 1` → all outputs take their reset values within the same cycle; after release with `d0` held high, `{a,b} = 00` is presented 2 cycles later.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types and constants for the sequential 4-to-2 encoder.
package encoder_pkg;

   localparam int CODE_W = 2;
   localparam int NREQ   = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } state_t;

   localparam logic [CODE_W-1:0] CODE_D0 = 2'd0;
   localparam logic [CODE_W-1:0] CODE_D1 = 2'd1;
   localparam logic [CODE_W-1:0] CODE_D2 = 2'd2;
   localparam logic [CODE_W-1:0] CODE_D3 = 2'd3;

endpackage

// File: rtl/four_to_two_encoder_if.sv
// Request lines, code handshake and overflow status of the 4-to-2 encoder.
interface four_to_two_encoder_if #(
   parameter int OVF_W = 8
);
   logic             d0;
   logic             d1;
   logic             d2;
   logic             d3;
   logic             a;
   logic             b;
   logic             valid;
   logic             ready;
   logic             ovf;
   logic [OVF_W-1:0] ovf_cnt;
   logic             idle;

   modport master (
      input  d0, d1, d2, d3, ready,
      output a, b, valid, ovf, ovf_cnt, idle
   );

   modport slave (
      output d0, d1, d2, d3, ready,
      input  a, b, valid, ovf, ovf_cnt, idle
   );
endinterface

// File: rtl/rise_detect.sv
// Per-bit 0->1 edge detector; prev clears on reset so a line already high counts once.
module rise_detect #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] rise
);
   logic [WIDTH-1:0] prev_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_reg <= '0;
      end else begin
         prev_reg <= d;
      end
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rise
      assign rise[gi] = d[gi] & ~prev_reg[gi];
   end
endmodule

// File: rtl/four_to_two_encoder.sv
// Sequential 4-to-2 encoder: captured request edges are presented one code at a time.
// Define ENC_RR_EN for round-robin selection instead of fixed priority d3 > d2 > d1 > d0.
module four_to_two_encoder
   import encoder_pkg::*;
#(
   parameter int OVF_W = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   four_to_two_encoder_if.master bus
);
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   rise;
   logic [NREQ-1:0]   clr;
   logic [NREQ-1:0]   drop;
   logic [NREQ-1:0]   pend_reg;
   logic [NREQ-1:0]   pend_next;
   state_t            state_reg;
   logic [CODE_W-1:0] code_reg;
   logic [CODE_W-1:0] sel;
   logic              load;
   logic              ovf_reg;
   logic [OVF_W-1:0]  cnt_reg;
   logic [OVF_W-1:0]  cnt_next;
   logic [2:0]        drop_cnt;
   logic [OVF_W+2:0]  cnt_sum;

   assign req = {bus.d3, bus.d2, bus.d1, bus.d0};

   rise_detect #(
      .WIDTH(NREQ)
   ) u_rise_detect (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (req),
      .rise (rise)
   );

`ifdef ENC_RR_EN
   logic [CODE_W-1:0] last_reg;

   // Nearest pending index after last wins; k = NREQ maps back onto last itself.
   function automatic logic [CODE_W-1:0] pick_rr(input logic [NREQ-1:0] p,
                                                input logic [CODE_W-1:0] last);
      logic [CODE_W-1:0] idx;
      pick_rr = last;
      for (int k = NREQ; k >= 1; k--) begin
         idx = last + CODE_W'(k);
         if (p[idx]) pick_rr = idx;
      end
   endfunction

   assign sel = pick_rr(pend_reg, last_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_reg <= CODE_D3;
      end else if (load) begin
         last_reg <= sel;
      end
   end
`else
   function automatic logic [CODE_W-1:0] pick_fixed(input logic [NREQ-1:0] p);
      pick_fixed = CODE_D0;
      if (p[1]) pick_fixed = CODE_D1;
      if (p[2]) pick_fixed = CODE_D2;
      if (p[3]) pick_fixed = CODE_D3;
   endfunction

   assign sel = pick_fixed(pend_reg);
`endif

   // Handshake sees only bits pending before this edge; fresh rises wait a cycle.
   assign load = (pend_reg != '0) && ((state_reg == ST_IDLE) || bus.ready);

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_pend
      assign clr[gi]       = load && (sel == CODE_W'(gi));
      assign drop[gi]      = rise[gi] & pend_reg[gi] & ~clr[gi];
      assign pend_next[gi] = (pend_reg[gi] & ~clr[gi]) | rise[gi];
   end

   always_comb begin
      drop_cnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         drop_cnt = drop_cnt + {2'b00, drop[i]};
      end
   end

   assign cnt_sum  = {3'b000, cnt_reg} + (OVF_W+3)'(drop_cnt);
   assign cnt_next = (|cnt_sum[OVF_W+2:OVF_W]) ? '1 : cnt_sum[OVF_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         code_reg  <= CODE_D0;
         pend_reg  <= '0;
         ovf_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         pend_reg <= pend_next;
         ovf_reg  <= |drop;
         cnt_reg  <= cnt_next;
         case (state_reg)
            ST_IDLE: begin
               if (load) begin
                  code_reg  <= sel;
                  state_reg <= ST_SHOW;
               end
            end
            ST_SHOW: begin
               if (bus.ready) begin
                  if (load) begin
                     code_reg <= sel;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.a       = code_reg[1];
   assign bus.b       = code_reg[0];
   assign bus.valid   = (state_reg == ST_SHOW);
   assign bus.ovf     = ovf_reg;
   assign bus.ovf_cnt = cnt_reg;
   assign bus.idle    = (state_reg == ST_IDLE) && (pend_reg == '0);
endmodule

// File: tb/tb_four_to_two_encoder.sv
// Directed bench for four_to_two_encoder: a pending-set model is checked every cycle,
// plus literal expectations; an OVF_W=2 copy shares the stimulus for saturation.
module tb_four_to_two_encoder;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic [3:0] d_in     = 4'b0000;
   logic       ready_in = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   four_to_two_encoder_if #(.OVF_W(8)) bus8 ();
   four_to_two_encoder_if #(.OVF_W(2)) bus2 ();

   assign bus8.d0 = d_in[0];
   assign bus8.d1 = d_in[1];
   assign bus8.d2 = d_in[2];
   assign bus8.d3 = d_in[3];
   assign bus8.ready = ready_in;
   assign bus2.d0 = d_in[0];
   assign bus2.d1 = d_in[1];
   assign bus2.d2 = d_in[2];
   assign bus2.d3 = d_in[3];
   assign bus2.ready = ready_in;

   four_to_two_encoder #(.OVF_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   four_to_two_encoder #(.OVF_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   // Behavioural model: set of pending requests, the code on display, total drops.
   logic [3:0] m_prev  = 4'b0000;
   logic [3:0] m_pend  = 4'b0000;
   logic       m_valid = 1'b0;
   int         m_code  = 0;
   int         m_last  = 3;
   logic       m_ovf   = 1'b0;
   int         m_drops = 0;

   function automatic int pick(input logic [3:0] p, input int last);
`ifdef ENC_RR_EN
      for (int k = 1; k <= 4; k++) begin
         if (p[(last + k) % 4]) return (last + k) % 4;
      end
`else
      for (int i = 3; i >= 0; i--) begin
         if (p[i]) return i;
      end
`endif
      return -1;
   endfunction

   task automatic model_reset();
      m_prev  = 4'b0000;
      m_pend  = 4'b0000;
      m_valid = 1'b0;
      m_code  = 0;
      m_last  = 3;
      m_ovf   = 1'b0;
      m_drops = 0;
   endtask

   // Advance the model across one clock edge with the inputs currently applied.
   task automatic model_step();
      logic [3:0] rise;
      int sel;
      int n;
      if (!rst_n) begin
         model_reset();
         return;
      end
      rise = d_in & ~m_prev;
      sel  = -1;
      if (m_pend != 4'b0000 && (!m_valid || ready_in)) sel = pick(m_pend, m_last);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (rise[i] && m_pend[i] && i != sel) n++;
      end
      if (sel >= 0) m_pend[sel] = 1'b0;
      m_pend = m_pend | rise;
      if (sel >= 0) begin
         m_valid = 1'b1;
         m_code  = sel;
         m_last  = sel;
      end else if (m_valid && ready_in) begin
         m_valid = 1'b0;
      end
      m_ovf   = (n > 0);
      m_drops = m_drops + n;
      m_prev  = d_in;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("valid", 32'(bus8.valid), 32'(m_valid));
      chk("idle", 32'(bus8.idle), 32'(!m_valid && m_pend == 4'b0000));
      if (m_valid) chk("code", 32'({bus8.a, bus8.b}), 32'(m_code));
      chk("ovf", 32'(bus8.ovf), 32'(m_ovf));
      chk("ovf_cnt8", 32'(bus8.ovf_cnt), 32'((m_drops > 255) ? 255 : m_drops));
      chk("valid_w2", 32'(bus2.valid), 32'(m_valid));
      if (m_valid) chk("code_w2", 32'({bus2.a, bus2.b}), 32'(m_code));
      chk("ovf_cnt2", 32'(bus2.ovf_cnt), 32'((m_drops > 3) ? 3 : m_drops));
   endtask

   // Apply inputs for one edge, then check at the following falling edge.
   task automatic tick(input logic [3:0] dv, input logic rv);
      d_in     = dv;
      ready_in = rv;
      if (bus8.valid && rv) $display("xfer code %0d", {bus8.a, bus8.b});
      model_step();
      @(negedge clk);
      compare_model();
   endtask

   initial begin
      int first_code;
      int second_code;
`ifdef ENC_RR_EN
      first_code  = 0;
      second_code = 3;
`else
      first_code  = 3;
      second_code = 0;
`endif

      repeat (3) tick(4'b0000, 1'b0);
      chk("rst_valid", 32'(bus8.valid), 32'd0);
      chk("rst_idle", 32'(bus8.idle), 32'd1);
      chk("rst_ab", 32'({bus8.a, bus8.b}), 32'd0);
      chk("rst_cnt", 32'(bus8.ovf_cnt), 32'd0);
      rst_n = 1'b1;

      // Simultaneous d0 and d3 edges held off by ready, then drained.
      tick(4'b1001, 1'b0);
      chk("mh_pend_valid", 32'(bus8.valid), 32'd0);
      tick(4'b1001, 1'b0);
      chk("mh_first", 32'({bus8.a, bus8.b}), 32'(first_code));
      tick(4'b1001, 1'b1);
      chk("mh_second", 32'({bus8.a, bus8.b}), 32'(second_code));
      chk("mh_second_valid", 32'(bus8.valid), 32'd1);
      tick(4'b1001, 1'b1);
      chk("mh_done", 32'(bus8.valid), 32'd0);
      tick(4'b0000, 1'b1);

      // Single d1 pulse with ready high: two-cycle latency, shown once.
      tick(4'b0010, 1'b1);
      chk("p1_valid0", 32'(bus8.valid), 32'd0);
      chk("p1_idle0", 32'(bus8.idle), 32'd0);
      tick(4'b0000, 1'b1);
      chk("p1_valid1", 32'(bus8.valid), 32'd1);
      chk("p1_code", 32'({bus8.a, bus8.b}), 32'd1);
      tick(4'b0000, 1'b1);
      chk("p1_valid_end", 32'(bus8.valid), 32'd0);
      chk("p1_idle_end", 32'(bus8.idle), 32'd1);

      // Code held stable while ready stays low.
      tick(4'b0100, 1'b0);
      tick(4'b0000, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick(4'b0000, 1'b0);
         chk("hold_code", 32'({bus8.a, bus8.b}), 32'd2);
         chk("hold_valid", 32'(bus8.valid), 32'd1);
      end

      // d2 re-rises while already pending: one drop, code 10 served once more.
      tick(4'b0100, 1'b0);
      tick(4'b0000, 1'b0);
      tick(4'b0100, 1'b0);
      chk("drop_ovf", 32'(bus8.ovf), 32'd1);
      chk("drop_cnt", 32'(bus8.ovf_cnt), 32'd1);
      tick(4'b0000, 1'b0);
      chk("drop_ovf_pulse", 32'(bus8.ovf), 32'd0);
      tick(4'b0000, 1'b1);
      chk("drop_serve", 32'({bus8.a, bus8.b}), 32'd2);
      tick(4'b0000, 1'b1);
      chk("drop_served_once", 32'(bus8.valid), 32'd0);

      // Five more drops on d1 while d3 is displayed: narrow counter saturates.
      tick(4'b1000, 1'b0);
      tick(4'b0000, 1'b0);
      tick(4'b0010, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick(4'b0000, 1'b0);
         tick(4'b0010, 1'b0);
      end
      chk("sat_cnt_w2", 32'(bus2.ovf_cnt), 32'd3);
      chk("sat_cnt_w8", 32'(bus8.ovf_cnt), 32'd6);
      repeat (3) tick(4'b0000, 1'b1);

      // Reset in the middle of a displayed code.
      tick(4'b0100, 1'b0);
      tick(4'b0000, 1'b0);
      chk("mid_valid_pre", 32'(bus8.valid), 32'd1);
      #2;
      rst_n = 1'b0;
      d_in  = 4'b0001;
      model_reset();
      #1;
      chk("ar_valid", 32'(bus8.valid), 32'd0);
      chk("ar_ab", 32'({bus8.a, bus8.b}), 32'd0);
      chk("ar_ovf", 32'(bus8.ovf), 32'd0);
      chk("ar_cnt", 32'(bus8.ovf_cnt), 32'd0);
      chk("ar_idle", 32'(bus8.idle), 32'd1);
      @(negedge clk);
      compare_model();
      rst_n = 1'b1;
      tick(4'b0001, 1'b1);
      chk("rel_valid0", 32'(bus8.valid), 32'd0);
      tick(4'b0001, 1'b1);
      chk("rel_valid1", 32'(bus8.valid), 32'd1);
      chk("rel_code", 32'({bus8.a, bus8.b}), 32'd0);
      tick(4'b0001, 1'b1);
      chk("rel_once", 32'(bus8.valid), 32'd0);
      tick(4'b0000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
